// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clock divider bank.
package clk_div_pkg;

  localparam int CNT_W_DEF    = 24;
  localparam int DEF_HALF_DEF = 2**23;
  localparam int TICK_W       = 8;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider slice: counter, toggle, shadow divisor and apply logic.
// Optional tick counter built when CLKDIV_TICKCNT_EN is defined.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned      CNT_W    = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEF_HALF_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             wr,
  input  logic [CNT_W-1:0] wdata,
`ifdef CLKDIV_TICKCNT_EN
  output logic [TICK_W-1:0] tick_cnt,
`endif
  output logic             pending,
  output logic             div_out,
  output logic             tick
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_half;
  logic [CNT_W-1:0] r_shadow;
  logic             r_pend;
  logic             r_div;
  logic             r_tick;
  logic [CNT_W-1:0] w_h;
  logic             w_term;

  // A zero divisor behaves as one.
  assign w_h    = (r_half == '0) ? CNT_W'(1) : r_half;
  assign w_term = (r_cnt == w_h - CNT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_half   <= DEF_HALF;
      r_shadow <= '0;
      r_pend   <= 1'b0;
      r_div    <= 1'b0;
      r_tick   <= 1'b0;
    end else if (clr) begin
      r_cnt  <= '0;
      r_div  <= 1'b0;
      r_tick <= 1'b0;
      if (wr) begin
        r_half <= wdata;
        r_pend <= 1'b0;
      end else if (r_pend) begin
        r_half <= r_shadow;
        r_pend <= 1'b0;
      end
    end else if (en) begin
      if (w_term) begin
        r_cnt  <= '0;
        r_div  <= ~r_div;
        r_tick <= 1'b1;
        if (r_pend) begin
          r_half <= r_shadow;
          r_pend <= 1'b0;
        end
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
        r_tick <= 1'b0;
      end
      if (wr) begin
        r_shadow <= wdata;
        r_pend   <= 1'b1;
      end
    end else begin
      r_tick <= 1'b0;
      if (r_pend) begin
        r_half <= r_shadow;
        r_pend <= 1'b0;
        r_cnt  <= '0;
      end
      if (wr) begin
        r_shadow <= wdata;
        r_pend   <= 1'b1;
      end
    end
  end

`ifdef CLKDIV_TICKCNT_EN
  logic [TICK_W-1:0] r_tcnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tcnt <= '0;
    end else if (clr) begin
      r_tcnt <= '0;
    end else if (en && w_term) begin
      r_tcnt <= r_tcnt + TICK_W'(1);
    end
  end

  assign tick_cnt = r_tcnt;
`endif

  assign pending = r_pend;
  assign div_out = r_div;
  assign tick    = r_tick;

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock divider with valid/ready config port.
// Define CLKDIV_TICKCNT_EN to add the per-channel tick_cnt output.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned      NUM_CH   = 4,
  parameter int unsigned      CNT_W    = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEF_HALF_DEF),
  localparam int              CH_W     = ch_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_clr,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
`ifdef CLKDIV_TICKCNT_EN
  output logic [NUM_CH*TICK_W-1:0] tick_cnt,
`endif
  output logic [NUM_CH-1:0] div_out,
  output logic [NUM_CH-1:0] tick
);

  localparam int EXT = 2**CH_W;

  logic [NUM_CH-1:0] w_pend;
  logic [NUM_CH-1:0] w_wr;
  logic [EXT-1:0]    w_pend_ext;
  logic              w_xfer;

  // Unused channel indices read as never pending, so writes there drop.
  always_comb begin
    w_pend_ext             = '0;
    w_pend_ext[NUM_CH-1:0] = w_pend;
  end

  assign cfg_ready = ~w_pend_ext[cfg_ch];
  assign w_xfer    = cfg_valid & cfg_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_wr[i] = w_xfer && (cfg_ch == CH_W'(i));

    clk_div_channel #(
      .CNT_W    (CNT_W),
      .DEF_HALF (DEF_HALF)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (en[i]),
      .clr      (sync_clr),
      .wr       (w_wr[i]),
      .wdata    (cfg_half),
`ifdef CLKDIV_TICKCNT_EN
      .tick_cnt (tick_cnt[i*TICK_W +: TICK_W]),
`endif
      .pending  (w_pend[i]),
      .div_out  (div_out[i]),
      .tick     (tick[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: vector table, directed
// sequences and random traffic against a countdown reference model.
module tb_clk_div_bank;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int DH  = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] en = '0;
  logic           sync_clr = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [1:0]     cfg_ch = '0;
  logic [CW-1:0]  cfg_half = '0;
  logic [NCH-1:0] div_out;
  logic [NCH-1:0] tick;
`ifdef CLKDIV_TICKCNT_EN
  logic [NCH*8-1:0] tick_cnt;
`endif

  clk_div_bank #(
    .NUM_CH   (NCH),
    .CNT_W    (CW),
    .DEF_HALF (8'd3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sync_clr  (sync_clr),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_half  (cfg_half),
`ifdef CLKDIV_TICKCNT_EN
    .tick_cnt  (tick_cnt),
`endif
    .div_out   (div_out),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: cycles left until the next toggle, per channel.
  int m_half[NCH];
  int m_shadow[NCH];
  int m_left[NCH];
  int m_tcnt[NCH];
  bit m_pend[NCH];
  bit m_div[NCH];
  bit m_tick[NCH];

  typedef struct {
    logic [3:0] en;
    logic [3:0] ediv;
    logic [3:0] etick;
  } vec_t;
  vec_t tbl[7];

  function automatic int eff(int h);
    return (h == 0) ? 1 : h;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NCH; i++) begin
      m_half[i] = DH; m_shadow[i] = 0; m_left[i] = DH;
      m_pend[i] = 0; m_div[i] = 0; m_tick[i] = 0; m_tcnt[i] = 0;
    end
  endfunction

  function automatic bit m_ready(int ch);
    return (ch >= NCH) || !m_pend[ch];
  endfunction

  function automatic void m_step(logic [3:0] e, bit clr, bit v,
                                 int ch, int d);
    bit acc;
    bit wr;
    acc = v && m_ready(ch);
    for (int i = 0; i < NCH; i++) begin
      wr = acc && (ch == i);
      if (clr) begin
        m_div[i] = 0; m_tick[i] = 0; m_tcnt[i] = 0;
        if (wr) begin m_half[i] = d; m_pend[i] = 0; end
        else if (m_pend[i]) begin m_half[i] = m_shadow[i]; m_pend[i] = 0; end
        m_left[i] = eff(m_half[i]);
      end else if (e[i]) begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          m_div[i] = !m_div[i];
          m_tick[i] = 1;
          m_tcnt[i] = (m_tcnt[i] + 1) % 256;
          if (m_pend[i]) begin m_half[i] = m_shadow[i]; m_pend[i] = 0; end
          m_left[i] = eff(m_half[i]);
        end else begin
          m_tick[i] = 0;
        end
        if (wr) begin m_shadow[i] = d; m_pend[i] = 1; end
      end else begin
        m_tick[i] = 0;
        if (m_pend[i]) begin
          m_half[i] = m_shadow[i]; m_pend[i] = 0;
          m_left[i] = eff(m_half[i]);
        end
        if (wr) begin m_shadow[i] = d; m_pend[i] = 1; end
      end
    end
  endfunction

  function automatic logic [3:0] m_divv();
    logic [3:0] r;
    for (int i = 0; i < NCH; i++) r[i] = m_div[i];
    return r;
  endfunction

  function automatic logic [3:0] m_tickv();
    logic [3:0] r;
    for (int i = 0; i < NCH; i++) r[i] = m_tick[i];
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge; drives one cycle and checks both sides.
  task automatic cyc(logic [3:0] e, bit clr, bit v, int ch, int d);
    en = e; sync_clr = clr; cfg_valid = v;
    cfg_ch = ch[1:0]; cfg_half = d[7:0];
    #1;
    chk("cfg_ready", int'(cfg_ready), int'(m_ready(ch)));
    @(posedge clk);
    m_step(e, clr, v, ch, d);
    @(negedge clk);
    chk("div_out", int'(div_out), int'(m_divv()));
    chk("tick", int'(tick), int'(m_tickv()));
`ifdef CLKDIV_TICKCNT_EN
    for (int i = 0; i < NCH; i++)
      chk($sformatf("tick_cnt%0d", i), int'(tick_cnt[i*8 +: 8]), m_tcnt[i]);
`endif
    cfg_valid = 1'b0; sync_clr = 1'b0;
  endtask

  // Asserts reset between edges and checks outputs clear at once.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_div", int'(div_out), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_ready", int'(cfg_ready), 1);
`ifdef CLKDIV_TICKCNT_EN
    chk("rst_tcnt", int'(tick_cnt), 0);
`endif
    m_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    tbl[0] = '{4'b0001, 4'b0000, 4'b0000};
    tbl[1] = '{4'b0001, 4'b0000, 4'b0000};
    tbl[2] = '{4'b0001, 4'b0001, 4'b0001};
    tbl[3] = '{4'b0001, 4'b0001, 4'b0000};
    tbl[4] = '{4'b0001, 4'b0001, 4'b0000};
    tbl[5] = '{4'b0001, 4'b0000, 4'b0001};
    tbl[6] = '{4'b0001, 4'b0000, 4'b0000};

    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    m_reset();
    chk("reset_div", int'(div_out), 0);
    chk("reset_tick", int'(tick), 0);
    chk("reset_ready", int'(cfg_ready), 1);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].en, 0, 0, 0, 0);
      chk($sformatf("tbl%0d_div", i), int'(div_out), int'(tbl[i].ediv));
      chk($sformatf("tbl%0d_tick", i), int'(tick), int'(tbl[i].etick));
    end

    // Reprogram a running channel; second write stalls until apply.
    cyc(4'b0001, 0, 1, 0, 5);
    en = 4'b0001; cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd9;
    #1 chk("blocked_ready", int'(cfg_ready), 0);
    cyc(4'b0001, 0, 1, 0, 9);
    repeat (14) cyc(4'b0001, 0, 0, 0, 0);

    // Zero divisor: tick held high, toggle every cycle.
    cyc(4'b0011, 0, 1, 1, 0);
    repeat (8) cyc(4'b0011, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(4'b0011, 0, 0, 0, 0);
      chk("h1_tick", int'(tick[1]), 1);
    end

    // Phase align two channels with sync_clr.
    cyc(4'b0011, 0, 1, 0, 3);
    cyc(4'b0011, 0, 1, 1, 4);
    repeat (6) cyc(4'b0011, 0, 0, 0, 0);
    cyc(4'b0011, 1, 0, 0, 0);
    chk("clr_div", int'(div_out[1:0]), 0);
    chk("clr_tick", int'(tick), 0);
    repeat (2) cyc(4'b0011, 0, 0, 0, 0);
    chk("clr_t0_early", int'(tick[0]), 0);
    cyc(4'b0011, 0, 0, 0, 0);
    chk("clr_t0", int'(tick[0]), 1);
    chk("clr_t1_early", int'(tick[1]), 0);
    cyc(4'b0011, 0, 0, 0, 0);
    chk("clr_t1", int'(tick[1]), 1);

    // Disabled channel applies a write on the next cycle.
    repeat (4) cyc(4'b0100, 0, 0, 0, 0);
    cyc(4'b0000, 0, 1, 2, 2);
    repeat (9) cyc(4'b0000, 0, 0, 0, 0);
    chk("hold_div2", int'(div_out[2]), 1);
    cyc(4'b0100, 0, 0, 0, 0);
    chk("reen_tick_a", int'(tick[2]), 0);
    cyc(4'b0100, 0, 0, 0, 0);
    chk("reen_tick_b", int'(tick[2]), 1);
    chk("reen_div2", int'(div_out[2]), 0);

    // Reset with a pending write outstanding.
    repeat (4) cyc(4'b1111, 0, 0, 0, 0);
    cyc(4'b1111, 0, 1, 3, 7);
    cfg_ch = 2'd3;
    #1 chk("pend_ready", int'(cfg_ready), 0);
    do_reset();
    repeat (8) cyc(4'b1000, 0, 0, 3, 0);

    // Tick count wrap at H=1.
    cyc(4'b0010, 1, 1, 1, 0);
    for (int k = 0; k < 256; k++) begin
      cyc(4'b0010, 0, 0, 0, 0);
`ifdef CLKDIV_TICKCNT_EN
      if (k == 254) chk("tcnt_255", int'(tick_cnt[15:8]), 255);
      if (k == 255) chk("tcnt_wrap", int'(tick_cnt[15:8]), 0);
`endif
    end

    for (int k = 0; k < 1500; k++) begin
      if (k % 500 == 499) do_reset();
      cyc(4'($urandom_range(0, 15) | 4'($urandom_range(0, 15))),
          $urandom_range(0, 63) == 0,
          $urandom_range(0, 2) == 0,
          int'($urandom_range(0, 3)),
          int'($urandom_range(0, 6)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
Multi-channel programmable clock divider, the parametrised successor of the fixed 24-bit ripple-free divider. Each channel produces a 50%-duty divided square wave and a one-cycle tick enable from the system clock. Half-period divisors are runtime-programmable through a valid/ready config port. New divisors apply glitch-free at the channel's next terminal count. Sits beside the top level, feeding LED blink, debounce sampling and display-scan logic.

Parameters:
NUM_CH, 4, number of independent divider channels (1..16)
CNT_W, 24, counter and divisor width in bits
DEF_HALF, 2**23, reset half-period divisor for every channel (out period = 2*DEF_HALF cycles)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
en  in  NUM_CH  per-channel run enable
sync_clr  in  1  synchronous clear of all channels (phase align)
cfg_valid  in  1  config write request
cfg_ready  out  1  config write accepted when high with cfg_valid
cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel
cfg_half  in  CNT_W  new half-period divisor; 0 treated as 1
div_out  out  NUM_CH  divided square wave, registered
tick  out  NUM_CH  one-cycle pulse at each div_out toggle, registered

Behaviour:
- Reset (rst=0, async): cnt=0, half=DEF_HALF, shadow=0, pending=0, div_out=0, tick=0 for all channels. Only cfg_ready is combinational; all other outputs come from registers.
- Counting: when en[i]=1, cnt counts 0..H-1, where H = max(half,1).
  - At cnt==H-1: next cycle cnt=0, div_out[i] toggles, tick[i]=1.
  - Otherwise tick[i]=0.
  - Period is 2*H cycles, duty exactly 50%, tick every H cycles.
  - H=1: div_out toggles every cycle and tick is held high continuously.
- en[i]=0: cnt and div_out hold, tick=0. Re-enable resumes from the held count with no extra tick.
- Config handshake: cfg_ready = !pending[cfg_ch] (combinational on cfg_ch). A transfer occurs when cfg_valid & cfg_ready. On transfer: shadow[cfg_ch] <= cfg_half, pending <= 1.
- Apply rules:
  - If the channel is enabled, pending applies at its next terminal count: half <= shadow, pending <= 0, cnt <= 0. That tick and toggle still occur, so the new period starts cleanly.
  - If en[i]=0, pending applies on the next cycle, with cnt <= 0 and div_out held.
- cfg_ch >= NUM_CH: transfer is accepted (cfg_ready=1) and discarded.
- sync_clr=1 (priority over counting):
  - All cnt <= 0, div_out <= 0, tick <= 0.
  - Every pending shadow is applied and pending cleared.
  - A transfer in the same cycle as sync_clr loads half directly without setting pending.
- Transfer on the same cycle as the target's terminal count: that terminal count uses the old half; pending is set and applies at the following terminal count.
- Reset mid-operation discards pending writes; half returns to DEF_HALF.
- Wrap-around: cnt never exceeds H-1. Shrinking half takes effect only via the apply rules, so cnt never overruns.

Optional Feature:
CLKDIV_TICKCNT_EN
- Defined: adds output tick_cnt (NUM_CH*8 bits), a per-channel 8-bit wrapping count of ticks. Reset to 0, cleared by sync_clr, frozen while en=0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package clk_div_pkg: CNT_W default, DEF_HALF default, CH_IDX_W helper function (clog2 with min 1), and tick-count width constant 8.
- Sub-module clk_div_channel: one counter/toggle/shadow/pending slice. The bank holds the generate loop, cfg_ready mux and cfg_ch decode.

Test Plan:
- Reset then en=4'b0001 with CNT_W=8, DEF_HALF=3 -> ch0 tick every 3 cycles, div_out period 6, high 3 cycles; other channels stay 0.
- cfg write ch0 half=5 while running -> cfg_ready[ch0] low until next terminal count; old period completes, then ticks every 5 cycles; second write blocked until apply.
- cfg_half=0 on ch1 with en set -> H=1, tick held high, div_out toggles each cycle.
- Run ch0 (half=3) and ch1 (half=4), pulse sync_clr -> next cycle both cnt=0 and div_out=0; ch0 tick 3 cycles later, ch1 tick 4 cycles later.
- Drop en[2] mid-count at cnt=1 for 10 cycles, write half=2 -> applies next cycle, cnt=0, div_out held, first tick 2 cycles after re-enable.
- Assert rst low mid-count with a pending write -> all outputs 0 asynchronously; after release half=DEF_HALF and pending cleared. With CLKDIV_TICKCNT_EN, tick_cnt=0 and it wraps 255->0.
